// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants and helpers for the pipelined parallel adder
package adder_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_CHUNK = 4;

  function automatic int calc_nstage(input int width, input int chunk);
    return width / chunk;
  endfunction

  function automatic bit chunk_cfg_ok(input int width, input int chunk);
    return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/pipelined_parallel_adder_stage.sv
// rtl/pipelined_parallel_adder_stage.sv - one carry-registered chunk stage (module adder_chunk_stage)
module adder_chunk_stage #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             v_in,
  input  logic             c_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] s_in,
  output logic             v_out,
  output logic             c_out,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [WIDTH-1:0] s_out
);

  localparam int LO = IDX * CHUNK;

  logic [CHUNK:0] chunk_sum;

  assign chunk_sum = {1'b0, a_in[LO +: CHUNK]} + {1'b0, b_in[LO +: CHUNK]}
                   + {{CHUNK{1'b0}}, c_in};

  // Operands travel with the beat; lower sum bits accumulate chunk by chunk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_out <= 1'b0;
      c_out <= 1'b0;
      a_out <= '0;
      b_out <= '0;
      s_out <= '0;
    end else if (en) begin
      v_out             <= v_in;
      c_out             <= chunk_sum[CHUNK];
      a_out             <= a_in;
      b_out             <= b_in;
      s_out             <= s_in;
      s_out[LO +: CHUNK] <= chunk_sum[CHUNK-1:0];
    end
  end

endmodule

// File: rtl/pipelined_parallel_adder.sv
// rtl/pipelined_parallel_adder.sv - pipelined add/subtract with valid/ready handshakes
module pipelined_parallel_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NSTAGE = calc_nstage(WIDTH, CHUNK);

  if (!chunk_cfg_ok(WIDTH, CHUNK)) begin : g_cfg_check
    $error("pipelined_parallel_adder: WIDTH must be a multiple of CHUNK");
  end

  logic             en;
  logic             pv [NSTAGE+1];
  logic             pc [NSTAGE+1];
  logic [WIDTH-1:0] pa [NSTAGE+1];
  logic [WIDTH-1:0] pb [NSTAGE+1];
  logic [WIDTH-1:0] ps [NSTAGE+1];

  // Whole pipeline moves together, so a stalled output freezes every stage.
  assign en       = !out_valid || out_ready;
  assign in_ready = rst_n && en;

  assign pv[0] = in_valid;
  assign pc[0] = sub ? 1'b1 : cin;
  assign pa[0] = a;
  assign pb[0] = sub ? ~b : b;
  assign ps[0] = '0;

  for (genvar i = 0; i < NSTAGE; i++) begin : g_stage
    adder_chunk_stage #(
      .WIDTH(WIDTH),
      .CHUNK(CHUNK),
      .IDX  (i)
    ) u_stage (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (en),
      .v_in (pv[i]),
      .c_in (pc[i]),
      .a_in (pa[i]),
      .b_in (pb[i]),
      .s_in (ps[i]),
      .v_out(pv[i+1]),
      .c_out(pc[i+1]),
      .a_out(pa[i+1]),
      .b_out(pb[i+1]),
      .s_out(ps[i+1])
    );
  end

  assign out_valid = pv[NSTAGE];
  assign sum       = ps[NSTAGE];
  assign cout      = pc[NSTAGE];
  assign overflow  = (pa[NSTAGE][WIDTH-1] == pb[NSTAGE][WIDTH-1])
                  && (ps[NSTAGE][WIDTH-1] != pa[NSTAGE][WIDTH-1]);

endmodule

// File: tb/tb_pipelined_parallel_adder.sv
// tb/tb_pipelined_parallel_adder.sv - directed self-checking bench for pipelined_parallel_adder
module tb_pipelined_parallel_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  pipelined_parallel_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_one(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                          input logic tcin, input logic tsub, input logic [15:0] esum,
                          input logic ecout, input logic eovf);
    a = ta; b = tb_; cin = tcin; sub = tsub; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF;
    @(posedge clk); @(posedge clk); #1;
    chk({tag, "_early_valid"}, {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_sum"}, {16'd0, sum}, {16'd0, esum});
    chk({tag, "_cout"}, {31'd0, cout}, {31'd0, ecout});
    chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, eovf});
    @(posedge clk); #1;
    chk({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int sent;
    int recv;
    logic        held;
    logic [15:0] held_sum;
    logic [15:0] exp_q[$];

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum", {16'd0, sum}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    send_one("single", 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0);
    send_one("ripple_ffff", 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'hFFFE, 1'b1, 1'b0);
    send_one("ripple_cin", 16'h000F, 16'h0000, 1'b1, 1'b0, 16'h0010, 1'b0, 1'b0);
    send_one("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    send_one("sub_neg", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    send_one("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Streaming: 8 back-to-back beats, result i = i * 0x1001.
    for (int c = 0; c < 12; c++) begin
      in_valid = (c < 8); a = 16'(c); b = 16'(16'h1000 * c); cin = 1'b0; sub = 1'b0;
      #1;
      if (c == 3) chk("stream_pre_valid", {31'd0, out_valid}, 32'd0);
      if (c >= 4) begin
        chk($sformatf("stream_valid_%0d", c - 4), {31'd0, out_valid}, 32'd1);
        chk($sformatf("stream_sum_%0d", c - 4), {16'd0, sum}, {16'd0, 16'(16'h1001 * (c - 4))});
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #1;
    chk("stream_after_valid", {31'd0, out_valid}, 32'd0);

    // Backpressure: 6 beats, out_ready low for three cycles mid-stream.
    sent = 0; recv = 0; held = 1'b0; held_sum = '0;
    for (int c = 0; c < 40 && recv < 6; c++) begin
      in_valid = (sent < 6);
      a = 16'(16'h0100 + sent); b = 16'(16'h0010 * sent); cin = 1'b0; sub = 1'b0;
      out_ready = !(c >= 4 && c < 7);
      #1;
      if (held) begin
        chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_hold_sum", {16'd0, sum}, {16'd0, held_sum});
      end
      if (out_valid && !out_ready) chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() > 0) chk($sformatf("bp_sum_%0d", recv), {16'd0, sum}, {16'd0, exp_q.pop_front()});
        else chk("bp_unexpected_beat", {31'd0, out_valid}, 32'd0);
        recv++;
      end
      held = out_valid && !out_ready;
      held_sum = sum;
      if (in_valid && in_ready) begin
        exp_q.push_back(16'(16'h0100 + 16'h0011 * sent));
        sent++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("bp_sent", sent, 6);
    chk("bp_recv", recv, 6);
    chk("bp_no_extra", {31'd0, out_valid}, 32'd0);

    // Reset mid-operation with a result already at the output.
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_pre_valid", {31'd0, out_valid}, 32'd1);
    chk("rst_mid_pre_cout", {31'd0, cout}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_sum", {16'd0, sum}, 32'd0);
    chk("rst_mid_cout", {31'd0, cout}, 32'd0);
    chk("rst_mid_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk($sformatf("rst_no_stale_%0d", c), {31'd0, out_valid}, 32'd0);
    end
    send_one("post_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
